// File: rtl/traffic_ctrl_n.sv
// Two-road traffic light controller with BCD phase countdown, pedestrian shortening,
// busy-road green extension, flashing-yellow offline mode and a 4-digit multiplexed display.
module traffic_ctrl_n #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned SCAN_DIV     = 50_000,
  parameter int unsigned MAIN_GREEN   = 30,
  parameter int unsigned MAIN_YELLOW  = 3,
  parameter int unsigned CROSS_GREEN  = 20,
  parameter int unsigned CROSS_YELLOW = 3,
  parameter int unsigned BUSY_EXT     = 15,
  parameter int unsigned PED_MIN      = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ONLINE,
  input  logic       BUSY,
  input  logic       PQm,
  input  logic       PQc,
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       CR,
  output logic       CY,
  output logic       CG,
  output logic [7:0] DS_OUT,
  output logic [3:0] DS_FLAG,
  output logic       ONLINELED
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_MG_CR = 3'd1,
    ST_MY_CR = 3'd2,
    ST_MR_CG = 3'd3,
    ST_MR_CY = 3'd4
  } state_t;

  // Durations are converted to BCD at elaboration and saturate at 99.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    int unsigned s;
    s = (v > 99) ? 99 : v;
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] res;
    if (v[3:0] != 4'd0) begin
      res = {v[7:4], v[3:0] - 4'd1};
    end else if (v[7:4] != 4'd0) begin
      res = {v[7:4] - 4'd1, 4'd9};
    end else begin
      res = 8'h00;
    end
    return res;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  localparam logic [7:0] LD_MG      = to_bcd(MAIN_GREEN);
  localparam logic [7:0] LD_MG_BUSY = to_bcd(MAIN_GREEN + BUSY_EXT);
  localparam logic [7:0] LD_MY      = to_bcd(MAIN_YELLOW);
  localparam logic [7:0] LD_CG      = to_bcd(CROSS_GREEN);
  localparam logic [7:0] LD_CY      = to_bcd(CROSS_YELLOW);
  localparam logic [7:0] LD_PED     = to_bcd(PED_MIN);

  logic          r_online;
  logic [TW-1:0] r_presc;
  logic          r_flash;
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic [5:0]    r_lamps;
  logic [SW-1:0] r_scan;
  logic [1:0]    r_dig;
  logic [7:0]    r_ds_out;
  logic [3:0]    r_ds_flag;

  logic          w_online_chg;
  logic          w_presc_wrap;
  logic          w_tick;
  logic          w_flash_nx;
  logic [7:0]    w_main_ld;
  logic          w_ped_hit;
  state_t        w_state_nx;
  logic [7:0]    w_cnt_nx;
  logic [5:0]    w_lamps_nx;
  logic          w_scan_wrap;
  logic [3:0]    w_digit;
  logic [7:0]    w_ds_out_nx;
  logic [3:0]    w_ds_flag_nx;

  // A change of ONLINE restarts the second prescaler and swallows a coincident tick.
  assign w_online_chg = ONLINE ^ r_online;
  assign w_presc_wrap = (r_presc == TW'(TICK_DIV - 1));
  assign w_tick       = w_presc_wrap & ~w_online_chg;
  assign w_flash_nx   = r_flash ^ w_tick;
  assign w_main_ld    = BUSY ? LD_MG_BUSY : LD_MG;
  assign w_ped_hit    = (((r_state == ST_MG_CR) && PQm) || ((r_state == ST_MR_CG) && PQc))
                        && (r_cnt > LD_PED);
  assign w_scan_wrap  = (r_scan == SW'(SCAN_DIV - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_online <= 1'b0;
      r_presc  <= '0;
      r_flash  <= 1'b0;
    end else begin
      r_online <= ONLINE;
      r_flash  <= w_flash_nx;
      if (w_online_chg || w_presc_wrap) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + TW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_OFF;
      r_cnt   <= 8'h00;
      r_lamps <= 6'b000000;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_lamps <= w_lamps_nx;
    end
  end

  // Pedestrian loads outrank the tick; offline outranks everything.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_lamps_nx = 6'b000000;
    if (!ONLINE) begin
      w_state_nx = ST_OFF;
      w_cnt_nx   = 8'h00;
    end else if (r_state == ST_OFF) begin
      w_state_nx = ST_MG_CR;
      w_cnt_nx   = w_main_ld;
    end else if (w_ped_hit) begin
      w_cnt_nx = LD_PED;
    end else if (w_tick) begin
      if (r_cnt <= 8'h01) begin
        case (r_state)
          ST_MG_CR: begin w_state_nx = ST_MY_CR; w_cnt_nx = LD_MY;     end
          ST_MY_CR: begin w_state_nx = ST_MR_CG; w_cnt_nx = LD_CG;     end
          ST_MR_CG: begin w_state_nx = ST_MR_CY; w_cnt_nx = LD_CY;     end
          ST_MR_CY: begin w_state_nx = ST_MG_CR; w_cnt_nx = w_main_ld; end
          default:  begin w_state_nx = ST_OFF;   w_cnt_nx = 8'h00;     end
        endcase
      end else begin
        w_cnt_nx = bcd_dec(r_cnt);
      end
    end else begin
      w_cnt_nx = r_cnt;
    end

    // Lamp order {MR, MY, MG, CR, CY, CG}
    case (w_state_nx)
      ST_OFF:   w_lamps_nx = {1'b0, w_flash_nx, 1'b0, 1'b0, w_flash_nx, 1'b0};
      ST_MG_CR: w_lamps_nx = 6'b001100;
      ST_MY_CR: w_lamps_nx = 6'b010100;
      ST_MR_CG: w_lamps_nx = 6'b100001;
      ST_MR_CY: w_lamps_nx = 6'b100010;
      default:  w_lamps_nx = 6'b000000;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_scan <= '0;
      r_dig  <= 2'd0;
    end else if (w_scan_wrap) begin
      r_scan <= '0;
      r_dig  <= r_dig + 2'd1;
    end else begin
      r_scan <= r_scan + SW'(1);
      r_dig  <= r_dig;
    end
  end

  // Odd digit indices are tens slots; both road pairs show the same phase counter.
  always_comb begin
    w_ds_flag_nx = 4'b1111;
    w_ds_out_nx  = 8'h00;
    w_digit      = 4'd0;
    if (r_state == ST_OFF) begin
      w_ds_flag_nx = 4'b1111;
      w_ds_out_nx  = 8'h00;
    end else begin
      w_ds_flag_nx = ~(4'b0001 << r_dig);
      if (r_dig[0]) begin
        w_digit     = r_cnt[7:4];
        w_ds_out_nx = (w_digit == 4'd0) ? 8'h00 : seg7(w_digit);
      end else begin
        w_digit     = r_cnt[3:0];
        w_ds_out_nx = seg7(w_digit);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ds_out  <= 8'h00;
      r_ds_flag <= 4'b1111;
    end else begin
      r_ds_out  <= w_ds_out_nx;
      r_ds_flag <= w_ds_flag_nx;
    end
  end

  assign {MR, MY, MG, CR, CY, CG} = r_lamps;
  assign DS_OUT    = r_ds_out;
  assign DS_FLAG   = r_ds_flag;
  assign ONLINELED = r_online;

endmodule
